// File: rtl/ex_stage.sv
// ex_stage: RV32 execute stage - operand forwarding, ALU, branch resolve, divider.
// Define RV32M_DIV_EN to build the iterative radix-2 divider; otherwise divides return 0.
package ex_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  typedef struct packed {
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] ImmExt;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic [4:0]  Rd;
    logic [3:0]  ALUControl;
    logic        ALUSrc;
    logic [2:0]  funct3;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic        MemWrite;
    logic        Branch;
    logic        Jump;
    logic        MulDiv;
  } idex_t;

  typedef struct packed {
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [4:0]  Rd;
    logic [31:0] PCPlus4;
    logic [31:0] ImmExt;
    logic [2:0]  funct3;
  } exmem_t;

endpackage

module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  idex_t           inputs,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic            FlushE,
  output exmem_t          outputs,
  output logic [XLEN-1:0] PCTargetE,
  output logic            PCSrcE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            BusyE
);

  logic [31:0] src_a, src_b, wdata;
  logic [31:0] alu_y, mul_y, div_y, res_y;
  logic        mul_op, div_op, jalr;
  logic        eq, lt, ltu, cond;
  logic signed [65:0] mul_a, mul_b, mul_p;
  logic [1:0]  unused_mul;

  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = inputs.RD1;
    endcase
    case (ForwardBE)
      2'b01:   wdata = ResultW;
      2'b10:   wdata = ALUResultM;
      default: wdata = inputs.RD2;
    endcase
    src_b = inputs.ALUSrc ? inputs.ImmExt : wdata;
  end

  always_comb begin
    alu_y = '0;
    case (inputs.ALUControl)
      ALU_ADD:  alu_y = src_a + src_b;
      ALU_SUB:  alu_y = src_a - src_b;
      ALU_AND:  alu_y = src_a & src_b;
      ALU_OR:   alu_y = src_a | src_b;
      ALU_XOR:  alu_y = src_a ^ src_b;
      ALU_SLT:  alu_y = {31'b0, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_y = {31'b0, src_a < src_b};
      ALU_SLL:  alu_y = src_a << src_b[4:0];
      ALU_SRL:  alu_y = src_a >> src_b[4:0];
      ALU_SRA:  alu_y = $signed(src_a) >>> src_b[4:0];
      ALU_LUI:  alu_y = src_b;
      default:  alu_y = '0;
    endcase
  end

  // rs1 is signed for MULH/MULHSU, rs2 only for MULH
  always_comb begin
    mul_a = 66'($signed({inputs.funct3[1:0] != 2'b11 && src_a[31], src_a}));
    mul_b = 66'($signed({inputs.funct3[1:0] == 2'b01 && src_b[31], src_b}));
    mul_p = mul_a * mul_b;
    mul_y = (inputs.funct3[1:0] == 2'b00) ? mul_p[31:0] : mul_p[63:32];
    unused_mul = mul_p[65:64];
  end

  always_comb begin
    eq   = src_a == wdata;
    lt   = $signed(src_a) < $signed(wdata);
    ltu  = src_a < wdata;
    cond = 1'b0;
    case (inputs.funct3)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt;
      3'b101:  cond = !lt;
      3'b110:  cond = ltu;
      3'b111:  cond = !ltu;
      default: cond = 1'b0;
    endcase
  end

  assign mul_op = inputs.MulDiv & ~inputs.funct3[2];
  assign div_op = inputs.MulDiv & inputs.funct3[2];

`ifdef RV32M_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_e;

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        rsel_q, rsel_d;
  logic        sgn, a_neg, b_neg, ge;
  logic [31:0] a_abs, b_abs;
  logic [32:0] shft;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      rsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      rsel_q  <= rsel_d;
    end
  end

  // dvd_q shifts the dividend out and the quotient in
  always_comb begin
    sgn     = ~inputs.funct3[0];
    a_neg   = sgn & src_a[31];
    b_neg   = sgn & wdata[31];
    a_abs   = a_neg ? -src_a : src_a;
    b_abs   = b_neg ? -wdata : wdata;
    shft    = {rem_q, dvd_q[31]};
    ge      = shft >= {1'b0, dvs_q};
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    rsel_d  = rsel_q;
    case (state_q)
      S_IDLE: begin
        if (div_op && !FlushE) begin
          negr_d = a_neg;
          rsel_d = inputs.funct3[1];
          negq_d = 1'b0;
          if (wdata == '0) begin
            dvd_d   = '1;
            rem_d   = a_abs;
            state_d = S_DONE;
          end else if (sgn && src_a == 32'h8000_0000 && wdata == '1) begin
            dvd_d   = 32'h8000_0000;
            rem_d   = '0;
            state_d = S_DONE;
          end else begin
            dvd_d   = a_abs;
            dvs_d   = b_abs;
            rem_d   = '0;
            negq_d  = a_neg ^ b_neg;
            cnt_d   = 5'd31;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        dvd_d = {dvd_q[30:0], ge};
        rem_d = ge ? 32'(shft - {1'b0, dvs_q}) : shft[31:0];
        if (cnt_q == 5'd0) state_d = S_DONE;
        else cnt_d = cnt_q - 5'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (FlushE) state_d = S_IDLE;
  end

  assign div_y = rsel_q ? (negr_q ? -rem_q : rem_q)
                        : (negq_q ? -dvd_q : dvd_q);
  assign BusyE = rst_n & div_op & (state_q != S_DONE) & ~FlushE;
`else
  logic unused_div;
  assign unused_div = clk ^ rst_n;
  assign div_y      = '0;
  assign BusyE      = 1'b0;
`endif

  // JAL decodes with ALUSrc=0, JALR with ALUSrc=1 (rs1 + imm)
  assign jalr = inputs.Jump & inputs.ALUSrc;

  always_comb begin
    res_y = div_op ? div_y : (mul_op ? mul_y : alu_y);
    outputs           = '0;
    outputs.RegWrite  = inputs.RegWrite & ~BusyE;
    outputs.ResultSrc = inputs.ResultSrc;
    outputs.MemWrite  = inputs.MemWrite & ~BusyE;
    outputs.ALUResult = res_y;
    outputs.WriteData = wdata;
    outputs.Rd        = inputs.Rd;
    outputs.PCPlus4   = inputs.PCPlus4;
    outputs.ImmExt    = inputs.ImmExt;
    outputs.funct3    = inputs.funct3;
    PCSrcE    = (inputs.Jump | (inputs.Branch & cond)) & ~BusyE;
    PCTargetE = jalr ? ((src_a + inputs.ImmExt) & ~32'd1)
                     : (inputs.PC + inputs.ImmExt);
  end

  assign Rs1E = inputs.Rs1;
  assign Rs2E = inputs.Rs2;
  assign RdE  = inputs.Rd;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized self-checking bench for ex_stage.
// Expected values come from plain-arithmetic reference functions.
module tb_ex_stage;
  import ex_pkg::*;

`ifdef RV32M_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  idex_t       in_b;
  logic [1:0]  fa, fb;
  logic [31:0] resw, alum;
  logic        flush;
  exmem_t      out_b;
  logic [31:0] pct;
  logic        pcsrc;
  logic [4:0]  rs1e, rs2e, rde;
  logic        busy;

  int n_chk;
  int n_pass;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
  } dv_t;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inputs    (in_b),
    .ForwardAE (fa),
    .ForwardBE (fb),
    .ResultW   (resw),
    .ALUResultM(alum),
    .FlushE    (flush),
    .outputs   (out_b),
    .PCTargetE (pct),
    .PCSrcE    (pcsrc),
    .Rs1E      (rs1e),
    .Rs2E      (rs2e),
    .RdE       (rde),
    .BusyE     (busy)
  );

  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] rf,
                                      input logic [31:0] w, input logic [31:0] m);
    return (s == 2'b01) ? w : (s == 2'b10) ? m : rf;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_LUI:  return b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic br_ref(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] mul_ref(input logic [1:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (f)
      2'd0:    p = {32'b0, a} * {32'b0, b};
      2'd1:    p = sa * sb;
      2'd2:    p = sa * ub;
      default: p = {32'b0, a} * {32'b0, b};
    endcase
    return (f == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic div_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int nbusy);
    logic [31:0] q, m;
    bit sg;
    sg = !f3[0];
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; m = a; nbusy = 1;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; m = 32'd0; nbusy = 1;
    end else if (sg) begin
      q = $signed(a) / $signed(b); m = $signed(a) % $signed(b); nbusy = 33;
    end else begin
      q = a / b; m = a % b; nbusy = 33;
    end
    r = f3[1] ? m : q;
    if (!DIV_ON) begin
      r = 32'd0; nbusy = 0;
    end
  endtask

  task automatic clear_in();
    in_b  = '0;
    fa    = 2'b00;
    fb    = 2'b00;
    resw  = '0;
    alum  = '0;
    flush = 1'b0;
  endtask

  task automatic set_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    clear_in();
    in_b.MulDiv   = 1'b1;
    in_b.funct3   = f3;
    in_b.RD1      = a;
    in_b.RD2      = b;
    in_b.RegWrite = 1'b1;
    in_b.Rd       = 5'd5;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_in();
    in_b.RD1 = 32'd10;
    in_b.RD2 = 32'd20;
    in_b.ALUControl = ALU_ADD;
    in_b.RegWrite = 1'b1;
    in_b.Rd = 5'd7;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy);
    else n_pass++;
    n_chk++;
    if (out_b.ALUResult !== 32'd30) $display("FAIL reset_add got %0d want 30", out_b.ALUResult);
    else n_pass++;
    n_chk++;
    if (out_b.RegWrite !== 1'b1 || rde !== 5'd7)
      $display("FAIL reset_ctl got rw=%0b rd=%0d want rw=1 rd=7", out_b.RegWrite, rde);
    else n_pass++;
    in_b.MulDiv = 1'b1;
    in_b.funct3 = 3'b101;
    #1;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL reset_div_busy got %0b want 0", busy);
    else n_pass++;
    @(posedge clk); #1;
    clear_in();
    rst_n = 1'b1;
  endtask

  task automatic test_alu_random();
    logic [31:0] a, wd, b, exp;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      clear_in();
      in_b.RD1 = $urandom;
      in_b.RD2 = $urandom;
      in_b.ImmExt = $urandom;
      in_b.PCPlus4 = $urandom;
      in_b.ALUControl = 4'($urandom_range(0, 10));
      in_b.ALUSrc = 1'($urandom_range(0, 1));
      in_b.RegWrite = 1'($urandom_range(0, 1));
      in_b.Rd = 5'($urandom);
      in_b.Rs1 = 5'($urandom);
      fa = 2'($urandom_range(0, 2));
      fb = 2'($urandom_range(0, 2));
      resw = $urandom;
      alum = $urandom;
      @(negedge clk);
      a = fwd(fa, in_b.RD1, resw, alum);
      wd = fwd(fb, in_b.RD2, resw, alum);
      b = in_b.ALUSrc ? in_b.ImmExt : wd;
      exp = alu_ref(in_b.ALUControl, a, b);
      n_chk++;
      if (out_b.ALUResult !== exp)
        $display("FAIL alu op=%0d got %h want %h", in_b.ALUControl, out_b.ALUResult, exp);
      else n_pass++;
      n_chk++;
      if (out_b.WriteData !== wd || out_b.RegWrite !== in_b.RegWrite ||
          out_b.PCPlus4 !== in_b.PCPlus4 || rs1e !== in_b.Rs1)
        $display("FAIL alu_pass got wd=%h rw=%0b want wd=%h rw=%0b",
                 out_b.WriteData, out_b.RegWrite, wd, in_b.RegWrite);
      else n_pass++;
    end
  endtask

  task automatic test_branch_random();
    logic [2:0] f3s [6];
    logic [31:0] a, wd, tgt;
    logic take;
    f3s = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      clear_in();
      in_b.RD1 = $urandom;
      in_b.RD2 = ($urandom_range(0, 3) == 0) ? in_b.RD1 : $urandom;
      in_b.PC = $urandom;
      in_b.ImmExt = $urandom;
      in_b.funct3 = f3s[$urandom_range(0, 5)];
      in_b.Branch = 1'b1;
      in_b.Jump = ($urandom_range(0, 3) == 0);
      in_b.ALUSrc = 1'($urandom_range(0, 1));
      fa = 2'($urandom_range(0, 2));
      fb = 2'($urandom_range(0, 2));
      resw = $urandom;
      alum = $urandom;
      @(negedge clk);
      a = fwd(fa, in_b.RD1, resw, alum);
      wd = fwd(fb, in_b.RD2, resw, alum);
      take = in_b.Jump || br_ref(in_b.funct3, a, wd);
      tgt = (in_b.Jump && in_b.ALUSrc) ? ((a + in_b.ImmExt) & 32'hFFFF_FFFE)
                                       : (in_b.PC + in_b.ImmExt);
      n_chk++;
      if (pcsrc !== take)
        $display("FAIL branch f3=%0d got %0b want %0b", in_b.funct3, pcsrc, take);
      else n_pass++;
      n_chk++;
      if (pct !== tgt) $display("FAIL target got %h want %h", pct, tgt);
      else n_pass++;
    end
  endtask

  task automatic test_fwd_branch();
    @(posedge clk); #1;
    clear_in();
    in_b.RD1 = 32'd99;
    in_b.RD2 = 32'd5;
    in_b.PC = 32'h100;
    in_b.ImmExt = 32'h40;
    in_b.Branch = 1'b1;
    fa = 2'b10;
    alum = 32'd5;
    @(negedge clk);
    n_chk++;
    if (pcsrc !== 1'b1 || pct !== 32'h140)
      $display("FAIL fwd_beq got take=%0b tgt=%h want 1 140", pcsrc, pct);
    else n_pass++;
  endtask

  task automatic test_mul_random();
    logic [31:0] exp;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      clear_in();
      in_b.MulDiv = 1'b1;
      in_b.funct3 = 3'($urandom_range(0, 3));
      in_b.RD1 = $urandom;
      in_b.RD2 = $urandom;
      @(negedge clk);
      exp = mul_ref(in_b.funct3[1:0], in_b.RD1, in_b.RD2);
      n_chk++;
      if (out_b.ALUResult !== exp)
        $display("FAIL mul f3=%0d got %h want %h", in_b.funct3, out_b.ALUResult, exp);
      else n_pass++;
    end
  endtask

  task automatic test_div();
    dv_t q[$];
    logic [31:0] exp;
    int eb, nb, bad;
    bit done;
    q.push_back('{3'b101, 32'd100, 32'd7});
    q.push_back('{3'b111, 32'd100, 32'd7});
    q.push_back('{3'b100, -32'sd20, 32'd3});
    q.push_back('{3'b110, -32'sd20, 32'd3});
    q.push_back('{3'b100, 32'd55, 32'd0});
    q.push_back('{3'b110, 32'd55, 32'd0});
    q.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF});
    q.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF});
    for (int i = 0; i < 8; i++) begin
      dv_t d;
      d.f3 = 3'($urandom_range(4, 7));
      d.a = $urandom;
      case ($urandom_range(0, 3))
        0: d.b = $urandom_range(1, 20);
        1: d.b = -$urandom_range(1, 20);
        2: d.b = 32'd0;
        default: d.b = $urandom;
      endcase
      q.push_back(d);
    end
    foreach (q[k]) begin
      @(posedge clk); #1;
      set_div(q[k].f3, q[k].a, q[k].b);
      div_ref(q[k].f3, q[k].a, q[k].b, exp, eb);
      nb = 0; bad = 0; done = 0;
      for (int c = 0; c < 100 && !done; c++) begin
        @(negedge clk);
        if (busy) begin
          nb++;
          if (out_b.RegWrite !== 1'b0) bad++;
          @(posedge clk); #1;
        end else done = 1;
      end
      n_chk++;
      if (!done) $display("FAIL div_timeout case %0d", k);
      else n_pass++;
      n_chk++;
      if (nb != eb) $display("FAIL div_busy case %0d got %0d want %0d", k, nb, eb);
      else n_pass++;
      n_chk++;
      if (out_b.ALUResult !== exp || out_b.RegWrite !== 1'b1)
        $display("FAIL div_result case %0d f3=%0d a=%h b=%h got %h want %h",
                 k, q[k].f3, q[k].a, q[k].b, out_b.ALUResult, exp);
      else n_pass++;
      n_chk++;
      if (bad != 0) $display("FAIL div_wr_gate case %0d got %0d writes want 0", k, bad);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    int eb, nb, bad;
    bit done;
    @(posedge clk); #1;
    set_div(3'b101, 32'd100, 32'd7);
    in_b.Jump = 1'b1;
    in_b.MemWrite = 1'b1;
    div_ref(3'b101, 32'd100, 32'd7, exp, eb);
    for (int r = 0; r < 2; r++) begin
      nb = 0; bad = 0; done = 0;
      for (int c = 0; c < 100 && !done; c++) begin
        @(negedge clk);
        if (busy) begin
          nb++;
          if (pcsrc !== 1'b0 || out_b.MemWrite !== 1'b0) bad++;
          @(posedge clk); #1;
        end else done = 1;
      end
      n_chk++;
      if (!done || nb != eb)
        $display("FAIL b2b_busy round %0d got %0d want %0d", r, nb, eb);
      else n_pass++;
      n_chk++;
      if (out_b.ALUResult !== exp || pcsrc !== 1'b1 || bad != 0)
        $display("FAIL b2b_result round %0d got %h take=%0b bad=%0d want %h 1 0",
                 r, out_b.ALUResult, pcsrc, bad, exp);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    logic [31:0] exp;
    int eb, nb;
    bit done;
    @(posedge clk); #1;
    set_div(3'b101, 32'd100, 32'd7);
    @(negedge clk);
    n_chk++;
    if (busy !== DIV_ON) $display("FAIL flush_pre_busy got %0b want %0b", busy, DIV_ON);
    else n_pass++;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) $display("FAIL flush_busy got %0b want 0", busy);
    else n_pass++;
    @(posedge clk); #1;
    clear_in();
    in_b.RD1 = 32'd3;
    in_b.RD2 = 32'd4;
    in_b.ALUControl = ALU_ADD;
    in_b.RegWrite = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || out_b.ALUResult !== 32'd7 || out_b.RegWrite !== 1'b1)
      $display("FAIL flush_add got busy=%0b y=%0d want 0 7", busy, out_b.ALUResult);
    else n_pass++;
    @(posedge clk); #1;
    set_div(3'b101, 32'd9, 32'd0);
    div_ref(3'b101, 32'd9, 32'd0, exp, eb);
    nb = 0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (busy) begin
        nb++;
        @(posedge clk); #1;
      end else done = 1;
    end
    n_chk++;
    if (nb != eb || out_b.ALUResult !== exp)
      $display("FAIL flush_idle got busy=%0d y=%h want %0d %h", nb, out_b.ALUResult, eb, exp);
    else n_pass++;
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] exp;
    int eb, nb;
    bit done;
    @(posedge clk); #1;
    set_div(3'b101, 32'd1234, 32'd5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (busy !== DIV_ON) $display("FAIL rst_pre_busy got %0b want %0b", busy, DIV_ON);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL rst_busy_drop got %0b want 0", busy);
    else n_pass++;
    clear_in();
    in_b.RD1 = 32'd99;
    in_b.RD2 = 32'd5;
    in_b.PC = 32'h100;
    in_b.ImmExt = 32'h40;
    in_b.Branch = 1'b1;
    fa = 2'b10;
    alum = 32'd5;
    #1;
    n_chk++;
    if (pcsrc !== 1'b1 || pct !== 32'h140)
      $display("FAIL rst_fwd_beq got take=%0b tgt=%h want 1 140", pcsrc, pct);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_div(3'b101, 32'd1234, 32'd5);
    div_ref(3'b101, 32'd1234, 32'd5, exp, eb);
    nb = 0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (busy) begin
        nb++;
        @(posedge clk); #1;
      end else done = 1;
    end
    n_chk++;
    if (nb != eb || out_b.ALUResult !== exp)
      $display("FAIL rst_restart got busy=%0d y=%h want %0d %h", nb, out_b.ALUResult, eb, exp);
    else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    clear_in();
    test_reset();
    test_alu_random();
    test_branch_random();
    test_fwd_branch();
    test_mul_random();
    test_div();
    test_back_to_back();
    test_flush();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
